layer_output_serializer: RTL and testbench

- Sits directly downstream of one layer's parallel neuron array, and upstream of the next layer's neurons.
- Collects the per-neuron activation outputs (each with its own single-cycle valid pulse, possibly skewed) into a full frame.
- Replays the frame one value per cycle as the serial myinput/myinputValid stream that every next-layer neuron consumes.
- The collection register doubles as a one-frame pending buffer, so a new frame can assemble while the previous one streams.

---
 rtl/layer_output_serializer_if.sv | 24 ++
 rtl/layer_output_serializer.sv | 107 ++++++++++
 tb/tb_layer_output_serializer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_output_serializer_if.sv
// Bundle between one layer's parallel neuron array and the serial stream that feeds the next layer.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface layer_output_serializer_if #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
);
  logic [numNeuron*dataWidth-1:0] neuron_out;
  logic [numNeuron-1:0]           neuron_valid;
  logic [dataWidth-1:0]           ser_data;
  logic                           ser_valid;
  logic                           ser_last;
  logic                           busy;
  logic                           overflow;

  modport slave (
    input  neuron_out, neuron_valid,
    output ser_data, ser_valid, ser_last, busy, overflow
  );

  modport master (
    output neuron_out, neuron_valid,
    input  ser_data, ser_valid, ser_last, busy, overflow
  );
endinterface

// File: rtl/layer_output_serializer.sv
// Collects skewed per-neuron activations into a frame and replays it one value per cycle.
// The collection register doubles as a one-frame pending buffer behind the streaming frame.
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input logic clk,
  input logic rst,
  layer_output_serializer_if.slave bus
);
  localparam int IDX_W = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeuron - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [numNeuron-1:0] coll_mask_q, coll_mask_d;
  logic [dataWidth-1:0] coll_data_q [numNeuron];
  logic [dataWidth-1:0] coll_data_d [numNeuron];
  logic [dataWidth-1:0] out_buf_q [numNeuron];
  logic [dataWidth-1:0] out_buf_d [numNeuron];
  logic [dataWidth-1:0] merged_s [numNeuron];
  logic [dataWidth-1:0] ser_data_q, ser_data_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_last_q, ser_last_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic                 at_last_s, complete_s, load_s;

  // Frame assembly, load decision and next-state/next-output computation
  always_comb begin
    at_last_s  = (state_q == STREAM) && (idx_q == LAST_IDX);
    complete_s = &(coll_mask_q | bus.neuron_valid);
    load_s     = complete_s && ((state_q == IDLE) || at_last_s);

    // A set mask bit means the slot is already owned: later pulses are duplicates.
    for (int i = 0; i < numNeuron; i++) begin
      merged_s[i]    = coll_mask_q[i] ? coll_data_q[i]
                                      : bus.neuron_out[i*dataWidth +: dataWidth];
      coll_data_d[i] = (bus.neuron_valid[i] && !coll_mask_q[i])
                       ? bus.neuron_out[i*dataWidth +: dataWidth] : coll_data_q[i];
      out_buf_d[i]   = load_s ? merged_s[i] : out_buf_q[i];
    end

    overflow_d  = overflow_q | (|(bus.neuron_valid & coll_mask_q));
    coll_mask_d = load_s ? {numNeuron{1'b0}} : (coll_mask_q | bus.neuron_valid);

    if (load_s) begin
      state_d = STREAM;
      idx_d   = {IDX_W{1'b0}};
    end else if (at_last_s) begin
      state_d = IDLE;
      idx_d   = {IDX_W{1'b0}};
    end else if (state_q == STREAM) begin
      state_d = STREAM;
      idx_d   = idx_q + IDX_W'(1);
    end else begin
      state_d = state_q;
      idx_d   = idx_q;
    end

    // Outputs are registered copies of the element selected for the coming cycle.
    ser_valid_d = (state_d == STREAM);
    ser_data_d  = ser_valid_d ? out_buf_d[idx_d] : {dataWidth{1'b0}};
    ser_last_d  = ser_valid_d && (idx_d == LAST_IDX);
    busy_d      = ser_valid_d;
  end

  // State, collection and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {IDX_W{1'b0}};
      coll_mask_q <= {numNeuron{1'b0}};
      for (int i = 0; i < numNeuron; i++) begin
        coll_data_q[i] <= {dataWidth{1'b0}};
        out_buf_q[i]   <= {dataWidth{1'b0}};
      end
      ser_data_q  <= {dataWidth{1'b0}};
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coll_mask_q <= coll_mask_d;
      coll_data_q <= coll_data_d;
      out_buf_q   <= out_buf_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.ser_data  = ser_data_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with numNeuron=4 and numNeuron=1 instances; expected
// serial elements are queued with their due cycle and compared every cycle against both DUTs.
module tb_layer_output_serializer;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  logic exp_ovf4;
  logic exp_ovf1;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  layer_output_serializer_if #(.numNeuron(4), .dataWidth(16)) if4 ();
  layer_output_serializer_if #(.numNeuron(1), .dataWidth(16)) if1 ();

  layer_output_serializer #(.numNeuron(4), .dataWidth(16)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );
  layer_output_serializer #(.numNeuron(1), .dataWidth(16)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut4();
    exp_t e;
    if (q4.size() > 0 && q4[0].due == cyc) begin
      e = q4.pop_front();
      chk("n4_valid", {31'd0, if4.ser_valid}, 32'd1);
      chk("n4_data",  {16'd0, if4.ser_data},  {16'd0, e.data});
      chk("n4_last",  {31'd0, if4.ser_last},  {31'd0, e.last});
      chk("n4_busy",  {31'd0, if4.busy},      32'd1);
    end else begin
      chk("n4_idle_valid", {31'd0, if4.ser_valid}, 32'd0);
      chk("n4_idle_data",  {16'd0, if4.ser_data},  32'd0);
      chk("n4_idle_last",  {31'd0, if4.ser_last},  32'd0);
      chk("n4_idle_busy",  {31'd0, if4.busy},      32'd0);
    end
    chk("n4_overflow", {31'd0, if4.overflow}, {31'd0, exp_ovf4});
  endtask

  task automatic check_dut1();
    exp_t e;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      chk("n1_valid", {31'd0, if1.ser_valid}, 32'd1);
      chk("n1_data",  {16'd0, if1.ser_data},  {16'd0, e.data});
      chk("n1_last",  {31'd0, if1.ser_last},  {31'd0, e.last});
    end else begin
      chk("n1_idle_valid", {31'd0, if1.ser_valid}, 32'd0);
      chk("n1_idle_data",  {16'd0, if1.ser_data},  32'd0);
    end
    chk("n1_overflow", {31'd0, if1.overflow}, {31'd0, exp_ovf1});
  endtask

  // Advance one clock, check both DUTs, then return the inputs to idle with junk data.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_dut4();
    check_dut1();
    if4.neuron_valid = 4'b0000;
    if4.neuron_out   = {4{16'hDEAD}};
    if1.neuron_valid = 1'b0;
    if1.neuron_out   = 16'hBEEF;
  endtask

  task automatic drive4(input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3);
    if4.neuron_valid = v;
    if4.neuron_out   = {d3, d2, d1, d0};
  endtask

  task automatic push4(input int due, input logic [15:0] d, input logic last);
    exp_t e;
    e.due = due; e.data = d; e.last = last;
    q4.push_back(e);
  endtask

  task automatic push_frame4(input int start, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
    push4(start,     d0, 1'b0);
    push4(start + 1, d1, 1'b0);
    push4(start + 2, d2, 1'b0);
    push4(start + 3, d3, 1'b1);
  endtask

  task automatic push1(input int due, input logic [15:0] d);
    exp_t e;
    e.due = due; e.data = d; e.last = 1'b1;
    q1.push_back(e);
  endtask

  initial begin
    int s_a;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    exp_ovf4 = 1'b0;
    exp_ovf1 = 1'b0;
    rst      = 1'b1;
    if4.neuron_valid = 4'b0000;
    if4.neuron_out   = {4{16'hDEAD}};
    if1.neuron_valid = 1'b0;
    if1.neuron_out   = 16'hBEEF;

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();

    // All four valids together
    drive4(4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF);
    push_frame4(cyc + 1, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF);
    step();
    repeat (5) step();

    // Skewed valids: n2 at t0, n0 at t3, n1+n3 at t5 -> stream from t6
    drive4(4'b0100, 16'hDEAD, 16'hDEAD, 16'h3333, 16'hDEAD);
    step();
    step();
    step();
    drive4(4'b0001, 16'h1111, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    step();
    step();
    drive4(4'b1010, 16'hDEAD, 16'h2222, 16'hDEAD, 16'h4444);
    push_frame4(cyc + 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    step();
    repeat (5) step();

    // Second frame arrives at idx 1 -> pending, streams with no gap
    drive4(4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    s_a = cyc + 1;
    push_frame4(s_a, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    step();
    step();
    drive4(4'b1111, 16'hB000, 16'hB001, 16'hB002, 16'hB003);
    push_frame4(s_a + 4, 16'hB000, 16'hB001, 16'hB002, 16'hB003);
    step();
    repeat (8) step();

    // Pending frame hit by a duplicate neuron 1 pulse -> sticky overflow, original data kept
    drive4(4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
    s_a = cyc + 1;
    push_frame4(s_a, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
    step();
    step();
    drive4(4'b1111, 16'hD000, 16'hD001, 16'hD002, 16'hD003);
    push_frame4(s_a + 4, 16'hD000, 16'hD001, 16'hD002, 16'hD003);
    step();
    drive4(4'b0010, 16'hDEAD, 16'hBAD0, 16'hDEAD, 16'hDEAD);
    exp_ovf4 = 1'b1;
    step();
    repeat (8) step();

    // Reset at stream idx 2 with partial mask 0011
    drive4(4'b1111, 16'hE000, 16'hE001, 16'hE002, 16'hE003);
    s_a = cyc + 1;
    push4(s_a,     16'hE000, 1'b0);
    push4(s_a + 1, 16'hE001, 1'b0);
    push4(s_a + 2, 16'hE002, 1'b0);
    step();
    drive4(4'b0001, 16'h0F00, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    step();
    drive4(4'b0010, 16'hDEAD, 16'h0F01, 16'hDEAD, 16'hDEAD);
    step();
    rst      = 1'b1;
    exp_ovf4 = 1'b0;
    step();
    rst = 1'b0;
    // Only n2/n3 first: the discarded partial mask must not complete this frame
    drive4(4'b1100, 16'hDEAD, 16'hDEAD, 16'h0C33, 16'h0D44);
    step();
    step();
    drive4(4'b0011, 16'h0A11, 16'h0B22, 16'hDEAD, 16'hDEAD);
    push_frame4(cyc + 1, 16'h0A11, 16'h0B22, 16'h0C33, 16'h0D44);
    step();
    repeat (6) step();

    // numNeuron=1: a frame every cycle, last on each element, no overflow
    if1.neuron_valid = 1'b1; if1.neuron_out = 16'd5;
    push1(cyc + 1, 16'd5);
    step();
    if1.neuron_valid = 1'b1; if1.neuron_out = 16'd6;
    push1(cyc + 1, 16'd6);
    step();
    if1.neuron_valid = 1'b1; if1.neuron_out = 16'd7;
    push1(cyc + 1, 16'd7);
    step();
    repeat (3) step();

    chk("sb4_drained", q4.size(), 32'd0);
    chk("sb1_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
